// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers generator pixel/line coordinates from a registered
// hsync/vsync/blank stream (active-low syncs). It runs a SEARCH -> HLOCK -> LOCKED
// lock machine and pulses error flags when sync edges arrive at the wrong position.
// Optional feature macro: BLANK_CHECK_EN. When it is defined, the incoming blank is
// compared with the blank implied by the recovered counts while LOCKED. When it is
// undefined, berr_out stays 0 and no comparison logic exists.
module vga_sync_decoder #(
  parameter int H_TOTAL      = 1344,
  parameter int V_TOTAL      = 806,
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int H_SYNC_START = 1048,
  parameter int V_SYNC_START = 772,
  parameter int LOCK_LINES   = 4
) (
  input  logic        vclock_in,
  input  logic        reset_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        blank_out,
  output logic        locked_out,
  output logic        frame_start_out,
  output logic        herr_out,
  output logic        verr_out,
  output logic        berr_out,
  output logic [7:0]  err_count_out
);

  localparam int                GOOD_W   = $clog2(LOCK_LINES + 1);
  localparam logic [10:0]       H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]       H_SYNC   = 11'(H_SYNC_START);
  localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]        V_SYNC   = 10'(V_SYNC_START);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_LINES);

  // Reject timing sets where the sync pulses would sit inside the visible area
  // or beyond the line/frame length.
  if (H_ACTIVE >= H_SYNC_START || V_ACTIVE >= V_SYNC_START ||
      H_SYNC_START >= H_TOTAL || V_SYNC_START >= V_TOTAL ||
      H_TOTAL > 2048 || V_TOTAL > 1024 || LOCK_LINES < 1) begin : g_bad_timing
    $error("vga_sync_decoder: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HLOCK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [GOOD_W-1:0] good;
  logic              hs_q;
  logic              vs_q;

  logic              hfall;
  logic              vfall;
  logic [10:0]       h_next;
  logic [9:0]        v_next;
  logic              h_ok;
  logic              v_ok;
  logic              herr_fire;
  logic              verr_fire;
  logic              berr_fire;
  logic              lock_hit;
  logic              any_err;

  // Free-run prediction, sync edge detection and the error/lock decisions for this cycle.
  always_comb begin
    hfall     = hs_q & ~hsync_in;
    vfall     = vs_q & ~vsync_in;
    h_next    = (hcount_out == H_LAST) ? 11'd0 : hcount_out + 11'd1;
    if (h_next != 11'd0) begin
      v_next = vcount_out;
    end else begin
      v_next = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
    end
    h_ok      = (h_next == H_SYNC);
    v_ok      = (h_next == 11'd0) && (v_next == V_SYNC);
    herr_fire = (state != SEARCH) && hfall && !h_ok;
    verr_fire = (state == LOCKED) && vfall && !v_ok;
    // A vsync fall only locks when no hsync fall competes for the same cycle.
    lock_hit  = (state == HLOCK) && vfall && !hfall &&
                (good == GOOD_MAX) && (h_next == 11'd0);
  end

`ifdef BLANK_CHECK_EN
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  logic blank_exp;

  // Blank implied by the counts about to be registered, checked only while LOCKED.
  always_comb begin
    blank_exp = (h_next >= H_ACT) || (v_next >= V_ACT);
    berr_fire = (state == LOCKED) && (blank_in != blank_exp);
  end
`else
  // Blank checking is compiled out; the berr path is a constant zero.
  always_comb begin
    berr_fire = 1'b0;
  end
`endif

  // One error count step per cycle, however many flags fire together.
  always_comb begin
    any_err = herr_fire | verr_fire | berr_fire;
  end

  // Lock state machine with registered counts, flags and error counter.
  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      state           <= SEARCH;
      good            <= '0;
      hs_q            <= 1'b0;
      vs_q            <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      blank_out       <= 1'b0;
      locked_out      <= 1'b0;
      frame_start_out <= 1'b0;
      herr_out        <= 1'b0;
      verr_out        <= 1'b0;
      berr_out        <= 1'b0;
      err_count_out   <= '0;
    end else begin
      hs_q            <= hsync_in;
      vs_q            <= vsync_in;
      blank_out       <= blank_in;
      herr_out        <= herr_fire;
      verr_out        <= verr_fire;
      berr_out        <= berr_fire;
      frame_start_out <= 1'b0;
      if (any_err && (err_count_out != 8'hFF)) begin
        err_count_out <= err_count_out + 8'd1;
      end

      case (state)
        SEARCH: begin
          locked_out <= 1'b0;
          hcount_out <= '0;
          vcount_out <= '0;
          if (hfall) begin
            hcount_out <= H_SYNC;
            good       <= '0;
            state      <= HLOCK;
          end
        end

        HLOCK: begin
          hcount_out <= h_next;
          vcount_out <= v_next;
          locked_out <= lock_hit;
          if (hfall) begin
            if (h_ok) begin
              if (good != GOOD_MAX) begin
                good <= good + GOOD_W'(1);
              end
            end else begin
              hcount_out <= H_SYNC;
              good       <= '0;
            end
          end else if (lock_hit) begin
            hcount_out <= '0;
            vcount_out <= V_SYNC;
            state      <= LOCKED;
          end
        end

        LOCKED: begin
          hcount_out <= h_next;
          vcount_out <= v_next;
          locked_out <= !(herr_fire || verr_fire);
          if (herr_fire) begin
            hcount_out <= H_SYNC;
          end
          if (herr_fire || verr_fire) begin
            good  <= '0;
            state <= HLOCK;
          end else if ((h_next == 11'd0) && (v_next == 10'd0)) begin
            frame_start_out <= 1'b1;
          end
        end

        default: begin
          locked_out <= 1'b0;
          good       <= '0;
          state      <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced timing set (40x20 frame) so that
// several frames fit in a short run. A small generator model produces the sync
// stream; expected values are hand-computed for that geometry.
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int VT  = 20;
  localparam int HA  = 24;
  localparam int VA  = 12;
  localparam int HS  = 28;
  localparam int VS  = 14;
  localparam int LL  = 4;
  localparam int HSW = 4;
  localparam int VSL = 2;
`ifdef BLANK_CHECK_EN
  localparam int BERR_EXP = 1;
`else
  localparam int BERR_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        blank_out;
  logic        locked_out;
  logic        frame_start_out;
  logic        herr_out;
  logic        verr_out;
  logic        berr_out;
  logic [7:0]  err_count_out;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_LINES(LL)
  ) dut (
    .vclock_in(clk), .reset_in(reset_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blank_in(blank_in), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .blank_out(blank_out), .locked_out(locked_out), .frame_start_out(frame_start_out),
    .herr_out(herr_out), .verr_out(verr_out), .berr_out(berr_out),
    .err_count_out(err_count_out)
  );

  typedef struct {
    string name;
    int    n;
    bit    lk;
    bit    fs;
    bit    bl;
    int    h;
    int    v;
    int    ec;
  } vec_t;

  vec_t tbl[13];
  int   tests = 0;
  int   fails = 0;
  int   gh, gv, ph, pv, n_applied;
  bit   vs_late = 1'b0;
  bit   blank_force0 = 1'b0;
  int   fs_seen, err_seen;

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_snap(input string name, input bit lk, input bit fs, input bit bl,
                            input int h, input int v, input int ec);
    tests++;
    if (locked_out !== lk || frame_start_out !== fs || blank_out !== bl ||
        hcount_out !== 11'(h) || vcount_out !== 10'(v) || err_count_out !== 8'(ec)) begin
      fails++;
      $display("FAIL %s: got lk=%0b fs=%0b bl=%0b h=%0d v=%0d ec=%0d expected lk=%0b fs=%0b bl=%0b h=%0d v=%0d ec=%0d",
               name, locked_out, frame_start_out, blank_out, hcount_out, vcount_out,
               err_count_out, lk, fs, bl, h, v, ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the generator position (gh,gv), clock it in, then advance the generator.
  task automatic gen_step();
    hsync_in = !(gh >= HS && gh < HS + HSW);
    vsync_in = !(gv >= VS && gv < VS + VSL) || (vs_late && gv == VS && gh < 5);
    blank_in = blank_force0 ? 1'b0 : (gh >= HA || gv >= VA);
    tick();
    ph = gh;
    pv = gv;
    n_applied++;
    if (gh == HT - 1) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    fs_seen  += int'(frame_start_out);
    err_seen += int'(herr_out | verr_out | berr_out);
  endtask

  task automatic run_until(input string name, input int h, input int v, input int max_steps);
    int k = 0;
    do begin
      gen_step();
      k++;
    end while (!(ph == h && pv == v) && k < max_steps);
    check_val({name, "_reached"}, (ph == h && pv == v) ? 1 : 0, 1);
  endtask

  initial begin
    tbl[0]  = '{"search_h23",    23,   1'b0, 1'b0, 1'b0, 0,  0,  0};
    tbl[1]  = '{"search_h27",    27,   1'b0, 1'b0, 1'b1, 0,  0,  0};
    tbl[2]  = '{"first_hfall",   28,   1'b0, 1'b0, 1'b1, 28, 0,  0};
    tbl[3]  = '{"hlock_h39",     39,   1'b0, 1'b0, 1'b1, 39, 0,  0};
    tbl[4]  = '{"hlock_wrap",    40,   1'b0, 1'b0, 1'b0, 0,  1,  0};
    tbl[5]  = '{"pre_lock",      559,  1'b0, 1'b0, 1'b1, 39, 13, 0};
    tbl[6]  = '{"lock_entry",    560,  1'b1, 1'b0, 1'b1, 0,  14, 0};
    tbl[7]  = '{"lock_run",      561,  1'b1, 1'b0, 1'b1, 1,  14, 0};
    tbl[8]  = '{"frame_end",     799,  1'b1, 1'b0, 1'b1, 39, 19, 0};
    tbl[9]  = '{"frame_start1",  800,  1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[10] = '{"after_fs",      801,  1'b1, 1'b0, 1'b0, 1,  0,  0};
    tbl[11] = '{"mid_active",    1000, 1'b1, 1'b0, 1'b0, 0,  5,  0};
    tbl[12] = '{"frame_start2",  1600, 1'b1, 1'b1, 1'b0, 0,  0,  0};

    // Reset with hsync already low, then release while it stays low.
    reset_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1; blank_in = 1'b0;
    repeat (3) tick();
    check_snap("reset_state", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_val("reset_flags", int'({herr_out, verr_out, berr_out}), 0);
    reset_in = 1'b0;
    repeat (3) tick();
    check_snap("hs_low_exit", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    hsync_in = 1'b1;
    tick();
    check_val("hs_high_search", int'(hcount_out), 0);
    hsync_in = 1'b0;
    tick();
    check_val("hs_genuine_fall", int'(hcount_out), HS);

    // Ideal stream from reset.
    reset_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    repeat (2) tick();
    reset_in = 1'b0;
    gh = 0; gv = 0; ph = -1; pv = -1; n_applied = -1; fs_seen = 0; err_seen = 0;
    for (int i = 0; i < 13; i++) begin
      while (n_applied < tbl[i].n) gen_step();
      check_snap(tbl[i].name, tbl[i].lk, tbl[i].fs, tbl[i].bl, tbl[i].h, tbl[i].v, tbl[i].ec);
    end
    check_val("fs_pulse_count", fs_seen, 2);
    check_val("ideal_err_pulses", err_seen, 0);

    // Shorten line 2 by one clock inside the horizontal blank.
    run_until("short_setup", 25, 2, 200);
    gh = 27;
    gen_step();
    check_snap("short_pre", 1'b1, 1'b0, 1'b1, 26, 2, 0);
    gen_step();
    check_val("short_herr", int'(herr_out), 1);
    check_snap("short_unlock", 1'b0, 1'b0, 1'b1, HS, 2, 1);
    run_until("relock_short", 0, 14, 1000);
    check_snap("relock_short", 1'b1, 1'b0, 1'b1, 0, 14, 1);

    // Blank forced low in the horizontal blank of an active line.
    run_until("blank_setup", 25, 3, 1000);
    blank_force0 = 1'b1;
    gen_step();
    blank_force0 = 1'b0;
    check_val("blank_berr", int'(berr_out), BERR_EXP);
    check_snap("blank_locked", 1'b1, 1'b0, 1'b0, 26, 3, 1 + BERR_EXP);
    gen_step();
    check_val("blank_berr_clear", int'(berr_out), 0);

    // Vsync falls at hcount 5 instead of 0.
    run_until("vlate_setup", 39, 13, 1000);
    vs_late = 1'b1;
    run_until("vlate_pre", 4, 14, 10);
    check_snap("vlate_pre", 1'b1, 1'b0, 1'b1, 4, 14, 1 + BERR_EXP);
    gen_step();
    vs_late = 1'b0;
    check_val("vlate_flags", int'({herr_out, verr_out}), 1);
    check_snap("vlate_unlock", 1'b0, 1'b0, 1'b1, 5, 14, 2 + BERR_EXP);
    gen_step();
    check_val("vlate_verr_clear", int'(verr_out), 0);
    check_val("vlate_h_continues", int'(hcount_out), 6);

    // One-cycle reset mid-line, then relock from scratch.
    run_until("midreset_setup", 15, 2, 1000);
    reset_in = 1'b1;
    gen_step();
    reset_in = 1'b0;
    check_snap("midreset_zero", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_val("midreset_flags", int'({herr_out, verr_out, berr_out}), 0);
    run_until("midreset_prelock", 39, 13, 1000);
    check_snap("midreset_prelock", 1'b0, 1'b0, 1'b1, 39, 11, 0);
    gen_step();
    check_snap("midreset_relock", 1'b1, 1'b0, 1'b1, 0, 14, 0);
    run_until("midreset_fs", 0, 0, 1000);
    check_snap("midreset_fs", 1'b1, 1'b1, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
